// File: rtl/microseq_pkg.sv
// Shared definitions for the microprogram sequencer.
// Holds the default microaddress width, the default stack depth and the
// opcode encoding driven on I_SEQ each cycle.
package microseq_pkg;

  localparam int AW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    OP_JZ   = 3'd0,  // jump to zero, empty the stack
    OP_CJS  = 3'd1,  // conditional jump to subroutine
    OP_CJP  = 3'd2,  // conditional jump
    OP_PUSH = 3'd3,  // push uPC, conditionally load counter
    OP_RFCT = 3'd4,  // repeat loop from stack top while counter != 0
    OP_CRTN = 3'd5,  // conditional return
    OP_LDCT = 3'd6,  // load counter
    OP_CONT = 3'd7   // continue
  } opcode_e;

endpackage

// File: rtl/microseq_stack.sv
// LIFO of return / loop addresses for the microprogram sequencer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears SP and entries)
//   push, pop    : one operation per cycle; pop on empty is ignored
//   clear        : empties the stack (SP <= 0), takes priority
//   push_data    : address written on push
//   top          : current top entry, 0 while empty
//   full, empty  : occupancy flags
// A push while full overwrites the top entry and leaves SP at DEPTH.
module microseq_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_m1;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  top_idx;

  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign sp_m1   = sp - SPW'(1);
  // sp < DEPTH whenever wr_idx is used, so the truncation is exact.
  assign wr_idx  = sp[IW-1:0];
  assign top_idx = sp_m1[IW-1:0];
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push) begin
      if (full) begin
        mem[top_idx] <= push_data;
      end else begin
        mem[wr_idx] <= push_data;
        sp          <= sp + SPW'(1);
      end
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer controller.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   I_SEQ      : instruction for this cycle (see microseq_pkg::opcode_e)
//   D          : branch address / counter load value
//   CC_N       : active-low condition, CCEN_N high forces the condition to pass
//   CI         : carry-in added to Y when the microPC is reloaded
//   Y          : next microaddress, combinational from state and inputs
//   FULL_N     : low when the stack holds DEPTH entries
//   CNT_ZERO   : high when loop counter R is 0
// uPC always holds the address following the one currently presented, so
// a "push uPC" saves the return address of the instruction after a call.
module microseq_ctrl
  import microseq_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [2:0]    I_SEQ,
  input  logic [AW-1:0] D,
  input  logic          CC_N,
  input  logic          CCEN_N,
  input  logic          CI,
  output logic [AW-1:0] Y,
  output logic          FULL_N,
  output logic          CNT_ZERO
);

  opcode_e       op;
  logic          pass;
  logic [AW-1:0] upc;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] stack_top;
  logic          stack_full;
  logic          stack_empty;
  logic          do_push;
  logic          do_pop;
  logic          do_clear;
  logic          r_load;
  logic          r_dec;

  assign op       = opcode_e'(I_SEQ);
  assign pass     = CCEN_N | ~CC_N;
  assign FULL_N   = ~stack_full;
  assign CNT_ZERO = (r_cnt == '0);

  always_comb begin
    Y        = upc;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_clear = 1'b0;
    r_load   = 1'b0;
    r_dec    = 1'b0;
    case (op)
      OP_JZ: begin
        Y        = '0;
        do_clear = 1'b1;
      end
      OP_CJS: begin
        if (pass) begin
          Y       = D;
          do_push = 1'b1;
        end
      end
      OP_CJP: begin
        if (pass) Y = D;
      end
      OP_PUSH: begin
        do_push = 1'b1;
        r_load  = pass;
      end
      OP_RFCT: begin
        if (!CNT_ZERO) begin
          Y     = stack_top;
          r_dec = 1'b1;
        end else begin
          do_pop = !stack_empty;
        end
      end
      OP_CRTN: begin
        if (pass) begin
          Y      = stack_top;
          do_pop = !stack_empty;
        end
      end
      OP_LDCT: r_load = 1'b1;
      OP_CONT: ;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      upc   <= '0;
      r_cnt <= '0;
    end else begin
      upc <= Y + AW'(CI);
      if (r_load)     r_cnt <= D;
      else if (r_dec) r_cnt <= r_cnt - AW'(1);
    end
  end

  microseq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (do_push),
    .pop       (do_pop),
    .clear     (do_clear),
    .push_data (upc),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed bench for microseq_ctrl (AW=8, DEPTH=4).
module tb_microseq_ctrl;
  import microseq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] i_seq;
  logic [7:0] d;
  logic       cc_n;
  logic       ccen_n;
  logic       ci;
  logic [7:0] y;
  logic       full_n;
  logic       cnt_zero;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  microseq_ctrl #(.AW(8), .DEPTH(4)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .I_SEQ    (i_seq),
    .D        (d),
    .CC_N     (cc_n),
    .CCEN_N   (ccen_n),
    .CI       (ci),
    .Y        (y),
    .FULL_N   (full_n),
    .CNT_ZERO (cnt_zero)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, compare Y against the scoreboard, then clock it.
  task automatic step(input opcode_e op, input logic [7:0] dv, input logic ccn,
                      input logic ccenn, input logic civ, input logic [7:0] exp_y,
                      input string tag);
    logic [7:0] e;
    i_seq  = op;
    d      = dv;
    cc_n   = ccn;
    ccen_n = ccenn;
    ci     = civ;
    exp_q.push_back(exp_y);
    #1;
    e = exp_q.pop_front();
    check(tag, {24'h0, y}, {24'h0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic state(input string tag, input logic [7:0] e_upc, input int e_sp,
                       input logic [7:0] e_r);
    check({tag, "_upc"}, {24'h0, dut.upc}, {24'h0, e_upc});
    check({tag, "_sp"}, 32'(dut.u_stack.sp), e_sp);
    check({tag, "_r"}, {24'h0, dut.r_cnt}, {24'h0, e_r});
  endtask

  initial begin
    rst_n  = 1'b0;
    i_seq  = OP_CONT;
    d      = 8'h00;
    cc_n   = 1'b1;
    ccen_n = 1'b1;
    ci     = 1'b1;
    #1;
    check("rst_y", {24'h0, y}, 32'h0);
    check("rst_full_n", {31'h0, full_n}, 32'h1);
    check("rst_cnt_zero", {31'h0, cnt_zero}, 32'h1);
    state("rst", 8'h00, 0, 8'h00);
    #6;  // a clock edge passes with reset held
    state("rst_held", 8'h00, 0, 8'h00);
    rst_n = 1'b1;

    // continue from zero
    step(OP_CONT, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, "cont0");
    step(OP_CONT, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, "cont1");
    step(OP_CONT, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, "cont2");
    state("cont", 8'h03, 0, 8'h00);

    // subroutine call / return
    step(OP_CJP, 8'h10, 1'b1, 1'b1, 1'b1, 8'h10, "cjp_10");
    step(OP_CJS, 8'h40, 1'b0, 1'b0, 1'b1, 8'h40, "cjs_pass");
    check("cjs_top", {24'h0, dut.stack_top}, 32'h11);
    state("cjs", 8'h41, 1, 8'h00);
    step(OP_CRTN, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, "crtn_fail");
    state("crtn_fail", 8'h42, 1, 8'h00);
    step(OP_CRTN, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, "crtn_pass");
    state("crtn", 8'h12, 0, 8'h00);
    step(OP_CJS, 8'h77, 1'b1, 1'b0, 1'b1, 8'h12, "cjs_fail");
    state("cjs_fail", 8'h13, 0, 8'h00);
    step(OP_CJP, 8'h99, 1'b1, 1'b0, 1'b1, 8'h13, "cjp_fail");

    // counted loop
    step(OP_CJP, 8'h20, 1'b1, 1'b1, 1'b1, 8'h20, "cjp_20");
    step(OP_PUSH, 8'h02, 1'b1, 1'b1, 1'b1, 8'h21, "push_pass");
    check("push_top", {24'h0, dut.stack_top}, 32'h21);
    check("push_cnt_zero", {31'h0, cnt_zero}, 32'h0);
    state("push", 8'h22, 1, 8'h02);
    step(OP_RFCT, 8'h00, 1'b1, 1'b1, 1'b1, 8'h21, "rfct1");
    state("rfct1", 8'h22, 1, 8'h01);
    step(OP_RFCT, 8'h00, 1'b1, 1'b1, 1'b1, 8'h21, "rfct2");
    check("rfct2_cnt_zero", {31'h0, cnt_zero}, 32'h1);
    step(OP_RFCT, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, "rfct3");
    state("rfct3", 8'h23, 0, 8'h00);
    check("rfct3_cnt_zero", {31'h0, cnt_zero}, 32'h1);
    step(OP_LDCT, 8'h05, 1'b1, 1'b0, 1'b1, 8'h23, "ldct");
    check("ldct_cnt_zero", {31'h0, cnt_zero}, 32'h0);
    state("ldct", 8'h24, 0, 8'h05);
    step(OP_PUSH, 8'h09, 1'b1, 1'b0, 1'b1, 8'h24, "push_fail");
    check("push_fail_top", {24'h0, dut.stack_top}, 32'h24);
    state("push_fail", 8'h25, 1, 8'h05);
    step(OP_JZ, 8'h55, 1'b1, 1'b1, 1'b1, 8'h00, "jz");
    state("jz", 8'h01, 0, 8'h05);

    // fill and overflow the stack
    step(OP_CJS, 8'h50, 1'b0, 1'b0, 1'b1, 8'h50, "fill1");
    step(OP_CJS, 8'h60, 1'b0, 1'b0, 1'b1, 8'h60, "fill2");
    step(OP_CJS, 8'h70, 1'b0, 1'b0, 1'b1, 8'h70, "fill3");
    check("fill3_full_n", {31'h0, full_n}, 32'h1);
    step(OP_CJS, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80, "fill4");
    check("fill4_full_n", {31'h0, full_n}, 32'h0);
    state("fill4", 8'h81, 4, 8'h05);
    check("fill4_top", {24'h0, dut.stack_top}, 32'h71);
    step(OP_CJS, 8'h90, 1'b0, 1'b0, 1'b1, 8'h90, "fill5");
    check("fill5_full_n", {31'h0, full_n}, 32'h0);
    check("fill5_top", {24'h0, dut.stack_top}, 32'h81);
    state("fill5", 8'h91, 4, 8'h05);
    step(OP_CRTN, 8'h00, 1'b1, 1'b1, 1'b1, 8'h81, "unfill");
    check("unfill_top", {24'h0, dut.stack_top}, 32'h61);
    check("unfill_full_n", {31'h0, full_n}, 32'h1);
    state("unfill", 8'h82, 3, 8'h05);

    // empty-stack return and microPC wrap
    step(OP_JZ, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, "jz2");
    step(OP_CRTN, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, "crtn_empty");
    state("crtn_empty", 8'h01, 0, 8'h05);
    step(OP_CJP, 8'hFE, 1'b1, 1'b1, 1'b1, 8'hFE, "cjp_fe");
    step(OP_CONT, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, "cont_ff");
    state("wrap", 8'h00, 0, 8'h05);
    step(OP_CONT, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, "cont_ci0");
    state("ci0", 8'h00, 0, 8'h05);

    // asynchronous reset in the middle of a loop
    step(OP_PUSH, 8'h03, 1'b1, 1'b1, 1'b1, 8'h00, "loop_push0");
    step(OP_CJP, 8'h30, 1'b1, 1'b1, 1'b1, 8'h30, "loop_cjp");
    step(OP_PUSH, 8'h03, 1'b1, 1'b1, 1'b1, 8'h31, "loop_push1");
    state("loop", 8'h32, 2, 8'h03);
    step(OP_RFCT, 8'h00, 1'b1, 1'b1, 1'b1, 8'h31, "loop_rfct");
    i_seq = OP_RFCT;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_full_n", {31'h0, full_n}, 32'h1);
    check("arst_cnt_zero", {31'h0, cnt_zero}, 32'h1);
    check("arst_y", {24'h0, y}, 32'h0);
    state("arst", 8'h00, 0, 8'h00);
    rst_n = 1'b1;
    step(OP_CONT, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, "post_rst_cont");
    state("post_rst", 8'h01, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
